// File: rtl/bram_axis_reader.sv
`default_nettype none
// ============================================================================
// Module      : bram_axis_reader
// Description : Replays a contiguous block of BRAM words as an AXI-Stream packet
//               with a 2-entry skid buffer to absorb downstream backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_axis_reader #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 10,
  parameter int C_LEN_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [C_ADDR_WIDTH-1:0]   base_addr,
  input  logic [C_LEN_WIDTH-1:0]    length,
  output logic                      busy,
  output logic                      done,
  output logic                      BRAM_EN,
  output logic [C_ADDR_WIDTH-1:0]   BRAM_ADDR,
  input  logic [C_DATA_WIDTH-1:0]   BRAM_OUT,
  output logic                      m00_axis_tvalid,
  output logic [C_DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                      m00_axis_tlast,
  input  logic                      m00_axis_tready
);

  localparam logic [C_ADDR_WIDTH-1:0] c_addr_one = C_ADDR_WIDTH'(1);
  localparam logic [C_LEN_WIDTH-1:0]  c_len_one  = C_LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_LEN_WIDTH-1:0]  remain_q, remain_d;
  logic                    done_q, done_d;
  logic                    rd_vld_q, rd_last_q;
  logic [C_DATA_WIDTH-1:0] buf_data_q [2];
  logic [1:0]              buf_last_q;
  logic                    rd_ptr_q, wr_ptr_q;
  logic [1:0]              count_q;

  logic       w_push, w_pop, w_issue, w_head_last;
  logic [2:0] w_used, w_limit;

  // A read is allowed only if its word is guaranteed a buffer slot on arrival.
  assign w_push      = rd_vld_q;
  assign w_pop       = (count_q != 2'd0) && m00_axis_tready;
  assign w_used      = {1'b0, count_q} + {2'b00, rd_vld_q};
  assign w_limit     = 3'd2 + {2'b00, w_pop};
  assign w_issue     = (state_q == S_RUN) && (remain_q != '0) && (w_used < w_limit);
  assign w_head_last = buf_last_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_d   = base_addr;
            remain_d = length;
            state_d  = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_issue) begin
          addr_d   = addr_q + c_addr_one;
          remain_d = remain_q - c_len_one;
          if (remain_q == c_len_one) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && w_head_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      remain_q      <= '0;
      done_q        <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_last_q     <= 1'b0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q    <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      done_q    <= done_d;
      rd_vld_q  <= w_issue;
      rd_last_q <= w_issue && (remain_q == c_len_one);
      if (w_push) begin
        buf_data_q[wr_ptr_q] <= BRAM_OUT;
        buf_last_q[wr_ptr_q] <= rd_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (w_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;
  assign BRAM_EN         = w_issue;
  assign BRAM_ADDR       = addr_q;
  assign m00_axis_tvalid = (count_q != 2'd0);
  assign m00_axis_tdata  = buf_data_q[rd_ptr_q];
  assign m00_axis_tlast  = m00_axis_tvalid && w_head_last;
  assign m00_axis_tstrb  = {(C_DATA_WIDTH/8){m00_axis_tvalid}};

endmodule
`default_nettype wire

// File: tb/tb_bram_axis_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_axis_reader
// Description : Randomized self-checking bench for bram_axis_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_axis_reader;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, bram_en, tvalid, tlast, tready;
  logic [AW-1:0] base_addr, bram_addr;
  logic [LW-1:0] length;
  logic [DW-1:0] bram_out, tdata;
  logic [DW/8-1:0] tstrb;

  always #5 clk = ~clk;

  bram_axis_reader #(.C_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW), .C_LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .BRAM_EN(bram_en), .BRAM_ADDR(bram_addr),
    .BRAM_OUT(bram_out), .m00_axis_tvalid(tvalid), .m00_axis_tdata(tdata),
    .m00_axis_tstrb(tstrb), .m00_axis_tlast(tlast), .m00_axis_tready(tready)
  );

  // Synchronous-read BRAM model
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) if (bram_en) bram_out <= mem[bram_addr];

  int n_pass = 0;
  int n_total = 0;

  logic [DW-1:0] obs_data [$];
  bit            obs_last [$];
  int            obs_beat_c [$];
  logic [AW-1:0] obs_addr [$];
  int            obs_en_c [$];
  int            obs_done_c [$];
  int            obs_busy_c [$];
  int            stab_err, credit_err;
  bit            timed_out;

  // Runs one transfer; mode 0 = tready always 1, 1 = 1,0,0 pattern, 2 = random.
  task automatic run_xfer(input int base, input int len, input int mode, input int inj_c);
    int issued = 0, popped = 0, done_at = -1;
    int limit = 4 * len + 20;
    bit pv = 0, pr = 0, pl = 0;
    logic [DW-1:0] pd = '0;
    obs_data.delete(); obs_last.delete(); obs_beat_c.delete(); obs_addr.delete();
    obs_en_c.delete(); obs_done_c.delete(); obs_busy_c.delete();
    stab_err = 0; credit_err = 0; timed_out = 1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(base); length = LW'(len);
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk); #1;
      start = (c == inj_c);
      if (c == inj_c) begin base_addr = '0; length = LW'(2); end
      case (mode)
        0:       tready = 1'b1;
        1:       tready = ((c - 1) % 3 == 0);
        default: tready = ($urandom_range(0, 1) == 1);
      endcase
      @(negedge clk);
      if (bram_en) begin obs_addr.push_back(bram_addr); obs_en_c.push_back(c); issued++; end
      if (tvalid && tready) begin
        obs_data.push_back(tdata); obs_last.push_back(tlast); obs_beat_c.push_back(c); popped++;
      end
      if (done) begin obs_done_c.push_back(c); if (done_at < 0) done_at = c; end
      if (busy) obs_busy_c.push_back(c);
      if (pv && !pr && !(tvalid && tdata === pd && tlast === pl)) stab_err++;
      if (issued - popped > 2) credit_err++;
      pv = tvalid; pr = tready; pd = tdata; pl = tlast;
      if (done_at >= 0 && c >= done_at + 2) begin timed_out = 0; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; tready = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (bram_en !== 1'b0) $display("FAIL reset_en: got %b want 0", bram_en); else n_pass++;
    n_total++; if (bram_addr !== '0) $display("FAIL reset_addr: got %0h want 0", bram_addr); else n_pass++;
    n_total++; if (tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", tvalid); else n_pass++;
    n_total++; if (tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", tlast); else n_pass++;
    n_total++; if (tdata !== '0) $display("FAIL reset_tdata: got %0h want 0", tdata); else n_pass++;
    n_total++; if (tstrb !== '0) $display("FAIL reset_tstrb: got %0h want 0", tstrb); else n_pass++;
  endtask

  task automatic test_basic;
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i + 32'h100);
    run_xfer(4, 4, 0, -1);
    n_total++; if (timed_out) $display("FAIL basic_timeout: no done seen"); else n_pass++;
    n_total++; if (obs_addr.size() != 4) $display("FAIL basic_nreads: got %0d want 4", obs_addr.size()); else n_pass++;
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      n_total++; if (obs_addr[i] !== AW'(4 + i) || obs_en_c[i] != 1 + i)
        $display("FAIL basic_read%0d: addr %0h cyc %0d want %0h cyc %0d", i, obs_addr[i], obs_en_c[i], 4 + i, 1 + i); else n_pass++;
    end
    n_total++; if (obs_data.size() != 4) $display("FAIL basic_nbeats: got %0d want 4", obs_data.size()); else n_pass++;
    for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
      n_total++; if (obs_data[i] !== DW'(32'h104 + i) || obs_beat_c[i] != 3 + i || obs_last[i] != (i == 3))
        $display("FAIL basic_beat%0d: data %0h cyc %0d last %0d want %0h cyc %0d last %0d",
                 i, obs_data[i], obs_beat_c[i], obs_last[i], 32'h104 + i, 3 + i, i == 3); else n_pass++;
    end
    n_total++; if (obs_done_c.size() != 1 || obs_done_c[0] != 7)
      $display("FAIL basic_done: count %0d want 1 at cycle 7", obs_done_c.size()); else n_pass++;
    n_total++; if (obs_busy_c.size() != 6 || obs_busy_c[0] != 1 || obs_busy_c[5] != 6)
      $display("FAIL basic_busy: %0d busy cycles want 6 (1..6)", obs_busy_c.size()); else n_pass++;
  endtask

  task automatic test_backpressure;
    int nlast = 0;
    run_xfer(0, 8, 1, -1);
    n_total++; if (timed_out) $display("FAIL bp_timeout: no done seen"); else n_pass++;
    n_total++; if (obs_data.size() != 8) $display("FAIL bp_nbeats: got %0d want 8", obs_data.size()); else n_pass++;
    for (int i = 0; i < obs_data.size(); i++) begin
      if (obs_last[i]) nlast++;
      n_total++; if (obs_data[i] !== mem[i] || obs_last[i] != (i == 7))
        $display("FAIL bp_beat%0d: data %0h last %0d want %0h last %0d", i, obs_data[i], obs_last[i], mem[i], i == 7); else n_pass++;
    end
    n_total++; if (nlast != 1) $display("FAIL bp_tlast_count: got %0d want 1", nlast); else n_pass++;
    n_total++; if (stab_err != 0) $display("FAIL bp_stable: %0d instability events want 0", stab_err); else n_pass++;
    n_total++; if (credit_err != 0) $display("FAIL bp_credit: %0d overcommit cycles want 0", credit_err); else n_pass++;
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    run_xfer(10'h3FE, 4, 0, -1);
    n_total++; if (obs_addr.size() != 4 || obs_data.size() != 4)
      $display("FAIL wrap_sizes: reads %0d beats %0d want 4/4", obs_addr.size(), obs_data.size()); else n_pass++;
    for (int i = 0; i < 4 && i < obs_addr.size() && i < obs_data.size(); i++) begin
      n_total++; if (obs_addr[i] !== AW'(10'h3FE + i) || obs_data[i] !== mem[(10'h3FE + i) % 1024])
        $display("FAIL wrap_%0d: addr %0h data %0h want %0h %0h", i, obs_addr[i], obs_data[i],
                 (10'h3FE + i) % 1024, mem[(10'h3FE + i) % 1024]); else n_pass++;
    end
  endtask

  task automatic test_degenerate;
    run_xfer(7, 0, 0, -1);
    n_total++; if (obs_done_c.size() != 1 || obs_done_c[0] != 1)
      $display("FAIL len0_done: count %0d want 1 at cycle 1", obs_done_c.size()); else n_pass++;
    n_total++; if (obs_data.size() != 0 || obs_addr.size() != 0 || obs_busy_c.size() != 0)
      $display("FAIL len0_quiet: beats %0d reads %0d busy %0d want 0/0/0",
               obs_data.size(), obs_addr.size(), obs_busy_c.size()); else n_pass++;
    run_xfer(33, 1, 0, -1);
    n_total++; if (obs_data.size() != 1 || obs_data[0] !== mem[33] || obs_last[0] != 1'b1)
      $display("FAIL len1_beat: beats %0d want 1 beat %0h with tlast", obs_data.size(), mem[33]); else n_pass++;
    n_total++; if (obs_done_c.size() != 1 || obs_done_c[0] != 4)
      $display("FAIL len1_done: count %0d want 1 at cycle 4", obs_done_c.size()); else n_pass++;
  endtask

  task automatic test_ignored_start;
    run_xfer(100, 6, 0, 3);
    n_total++; if (obs_data.size() != 6) $display("FAIL ign_nbeats: got %0d want 6", obs_data.size()); else n_pass++;
    for (int i = 0; i < obs_data.size(); i++) begin
      n_total++; if (obs_data[i] !== mem[100 + i] || obs_last[i] != (i == 5))
        $display("FAIL ign_beat%0d: data %0h want %0h", i, obs_data[i], mem[100 + i]); else n_pass++;
    end
    n_total++; if (obs_done_c.size() != 1) $display("FAIL ign_done: got %0d want 1", obs_done_c.size()); else n_pass++;
  endtask

  task automatic test_random;
    for (int t = 0; t < 4; t++) begin
      int base = $urandom_range(0, 1023);
      int len  = $urandom_range(1, 24);
      int bad  = 0;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      run_xfer(base, len, 2, -1);
      n_total++; if (obs_data.size() != len || timed_out)
        $display("FAIL rnd%0d_nbeats: got %0d want %0d", t, obs_data.size(), len); else n_pass++;
      for (int i = 0; i < obs_data.size(); i++)
        if (obs_data[i] !== mem[(base + i) % 1024] || obs_last[i] != (i == len - 1)) bad++;
      n_total++; if (bad != 0) $display("FAIL rnd%0d_data: %0d wrong beats want 0", t, bad); else n_pass++;
      n_total++; if (stab_err != 0 || credit_err != 0 || obs_done_c.size() != 1)
        $display("FAIL rnd%0d_rules: stab %0d credit %0d done %0d want 0/0/1", t, stab_err,
                 credit_err, obs_done_c.size()); else n_pass++;
    end
  endtask

  task automatic test_reset_midop;
    int beats = 0, late = 0;
    bit hit = 0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(16); length = LW'(8); tready = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      tready = (beats < 2);
      @(negedge clk);
      if (tvalid && tready) beats++;
      if (beats >= 2 && tvalid && !tready) begin hit = 1; break; end
    end
    n_total++; if (!hit) $display("FAIL rstmid_reach: beat 3 never presented"); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; tready = 1'b1;
    @(negedge clk);
    n_total++; if (tvalid !== 1'b0 || busy !== 1'b0 || bram_en !== 1'b0 || done !== 1'b0)
      $display("FAIL rstmid_outputs: tvalid %b busy %b en %b done %b want 0000", tvalid, busy, bram_en, done); else n_pass++;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || tvalid || bram_en) late++;
    end
    n_total++; if (late != 0) $display("FAIL rstmid_quiet: %0d active cycles want 0", late); else n_pass++;
    run_xfer(40, 3, 0, -1);
    n_total++; if (obs_data.size() != 3 || obs_done_c.size() != 1)
      $display("FAIL rstmid_restart: beats %0d done %0d want 3/1", obs_data.size(), obs_done_c.size()); else n_pass++;
    for (int i = 0; i < obs_data.size(); i++) begin
      n_total++; if (obs_data[i] !== mem[40 + i])
        $display("FAIL rstmid_beat%0d: data %0h want %0h", i, obs_data[i], mem[40 + i]); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tready = 1'b0; base_addr = '0; length = '0; bram_out = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_degenerate();
    test_ignored_start();
    test_random();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
